pwm_capture: RTL and testbench

- Receive-side counterpart to the push PWM generator: measures an incoming PWM waveform and reports high time and period in clk cycles.
- Used in loopback checks of the push PWM output and for reading external PWM feedback (servo/encoder style signals).
- Measurements are published once per PWM period, with a single-cycle valid strobe.
- Detects a stuck line (no rising edge within TIMEOUT cycles) and reports the stuck level.

---
 rtl/pwm_capture_pkg.sv | 9 +
 rtl/pwm_capture_sync_edge_det.sv | 34 +++
 rtl/pwm_capture.sv | 138 +++++++++++++
 tb/tb_pwm_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types for the PWM capture block: measurement FSM state encoding.
package pwm_capture_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a delay flop that
// yields single-cycle rise and fall pulses on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM signal in clk cycles,
// publishing one strobed measurement per period and flagging a stuck line.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int          CNT_W   = 20,
  parameter int unsigned TIMEOUT = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_IDLE_LIM = CNT_W'(TIMEOUT - 1);

  logic pwm_s2;
  logic pwm_rise;
  logic fall_unused;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (pwm_s2),
    .rise  (pwm_rise),
    .fall  (fall_unused)
  );

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] per_cnt_q,     per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,      hi_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q,    idle_cnt_d;
  logic [CNT_W-1:0] high_time_q,   high_time_d;
  logic [CNT_W-1:0] period_q,      period_d;
  logic             meas_valid_q,  meas_valid_d;
  logic             stuck_q,       stuck_d;
  logic             stuck_level_q, stuck_level_d;

  // NOTE: every variable gets its hold/default value first so no path through
  // the case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    high_time_d   = high_time_q;
    period_d      = period_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    case (state_q)
      ST_IDLE: begin
        if (pwm_rise) begin
          per_cnt_d  = ONE;
          hi_cnt_d   = ONE;
          idle_cnt_d = '0;
          stuck_d    = 1'b0;
          state_d    = ST_MEAS;
        end else if (idle_cnt_q == TO_IDLE_LIM) begin
          // The idle counter restarts even while stuck so it never wraps;
          // only the first timeout publishes a stuck event.
          idle_cnt_d = '0;
          if (!stuck_q) begin
            stuck_d       = 1'b1;
            stuck_level_d = pwm_s2;
            period_d      = '0;
            high_time_d   = '0;
            meas_valid_d  = 1'b1;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + ONE;
        end
      end

      ST_MEAS: begin
        if (pwm_rise) begin
          period_d     = per_cnt_q;
          high_time_d  = hi_cnt_q;
          meas_valid_d = 1'b1;
          per_cnt_d    = ONE;
          hi_cnt_d     = ONE;
        end else if (per_cnt_q == TO_LIMIT) begin
          stuck_d       = 1'b1;
          stuck_level_d = pwm_s2;
          period_d      = '0;
          high_time_d   = '0;
          meas_valid_d  = 1'b1;
          idle_cnt_d    = '0;
          state_d       = ST_IDLE;
        end else begin
          per_cnt_d = per_cnt_q + ONE;
          hi_cnt_d  = hi_cnt_q + CNT_W'(pwm_s2);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      high_time_q   <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      high_time_q   <= high_time_d;
      period_q      <= period_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign high_time   = high_time_q;
  assign period      = period_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected measurements
// (values and arrival cycle), a negedge monitor pops one per meas_valid.
module tb_pwm_capture;

  localparam int CNT_W = 20;
  localparam int T     = 120;  // must exceed the longest bench period (100)

  typedef struct {
    int per;
    int hi;
    bit stk;
    bit lvl;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  exp_t exp_q[$];
  int   ncyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   have_prev = 1'b0;
  int   prev_p    = 0;
  int   prev_h    = 0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
  endtask

  task automatic push_exp(input int per, input int hi, input bit stk, input bit lvl, input int cyc);
    exp_t e;
    e.per = per; e.hi = hi; e.stk = stk; e.lvl = lvl; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // All drive tasks are entered at a negedge and return at a negedge.
  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // A rise driven now closes the previous period; its result appears 3 cycles on.
  task automatic rise_mark(input int h, input int p);
    if (have_prev) push_exp(prev_p, prev_h, 1'b0, 1'b0, ncyc + 3);
    have_prev = 1'b1;
    prev_p    = p;
    prev_h    = h;
  endtask

  task automatic pulse(input int h, input int p);
    rise_mark(h, p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  // Closing rise, then the line stays low until the measuring timeout fires.
  task automatic close_and_timeout(input int h);
    if (have_prev) push_exp(prev_p, prev_h, 1'b0, 1'b0, ncyc + 3);
    push_exp(0, 0, 1'b1, 1'b0, ncyc + T + 3);
    have_prev = 1'b0;
    drive(1'b1, h);
    drive(1'b0, T + 10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_time"},   int'(high_time),   0);
    check({tag, "_period"},      int'(period),      0);
    check({tag, "_meas_valid"},  int'(meas_valid),  0);
    check({tag, "_stuck"},       int'(stuck),       0);
    check({tag, "_stuck_level"}, int'(stuck_level), 0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_meas_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("meas_cycle",     ncyc,            e.cyc);
        check("meas_period",    int'(period),    e.per);
        check("meas_high_time", int'(high_time), e.hi);
        check("meas_stuck",     int'(stuck),     int'(e.stk));
        if (e.stk) check("meas_stuck_level", int'(stuck_level), int'(e.lvl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);

    // Constant low from reset: one idle timeout, level 0.
    rst = 1'b0;
    rel = ncyc;
    check_all_zero("reset");
    push_exp(0, 0, 1'b1, 1'b0, rel + T);
    repeat (3 * T) @(negedge clk);
    check("stuck_low_held", int'(stuck), 1);

    // Constant high through reset: reset-release acts as a rise, then one
    // measuring timeout with level 1 and no repeats.
    pwm_in = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rel = ncyc;
    push_exp(0, 0, 1'b1, 1'b1, rel + T + 3);
    repeat (3 * T) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    check("stuck_high_held", int'(stuck), 1);
    check("stuck_high_level", int'(stuck_level), 1);

    // Recovery with high 3 / period 8: stuck clears on the first rise.
    have_prev = 1'b0;
    pulse(3, 8);
    check("stuck_cleared", int'(stuck), 0);
    pulse(3, 8);
    pulse(3, 8);
    close_and_timeout(3);

    // Period 100: high 10, then duty change to 5.
    repeat (3) pulse(10, 100);
    repeat (3) pulse(5, 100);
    close_and_timeout(5);

    // Extremes: 1/2 and 99/100.
    repeat (4) pulse(1, 2);
    repeat (2) pulse(99, 100);
    close_and_timeout(99);

    // Reset mid-high: the in-progress period is discarded.
    pulse(20, 40);
    pulse(20, 40);
    rise_mark(20, 40);
    drive(1'b1, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    have_prev = 1'b0;
    pulse(12, 30);
    pulse(20, 40);
    close_and_timeout(20);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
